tx_frame_ctrl: RTL and testbench

Frame sequencer for the TX modem chain (PRBS bit generator, 16-QAM mapper, zero-insert upsampler, RRC filters). It owns the symbol-rate timing and emits one symbol strobe every SPS enabled clocks. It also tags each symbol slot with its source: fixed preamble pattern, PRBS payload, or zero guard. A frame is PREAMBLE_LEN preamble symbols, then payload_len PRBS symbols, then GUARD_LEN zero symbols. Frames run single-shot or back-to-back.

---
 rtl/gdsp_pkg.sv | 9 +
 rtl/tx_sym_timer.sv | 20 ++
 rtl/tx_frame_ctrl.sv | 81 ++++++++
 tb/tb_tx_frame_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gdsp_pkg.sv
// gdsp_pkg: shared TX DSP constants, symbol-source and frame-state types
package gdsp_pkg;
  localparam int SPS = 4;
  localparam int BITS_PER_SYM = 4;
  typedef enum logic [1:0] {SRC_PRE = 2'd0, SRC_PRBS = 2'd1, SRC_ZERO = 2'd2} sym_src_t;
  typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, PAYLOAD = 2'd2, GUARD = 2'd3} tx_frm_state_t;
  localparam logic [BITS_PER_SYM-1:0] PRE_SYM_A = 4'h0;
  localparam logic [BITS_PER_SYM-1:0] PRE_SYM_B = 4'hF;
endpackage

// File: rtl/tx_sym_timer.sv
// tx_sym_timer: SPS sample divider (clk, rst, clr zeroes count, en advances, last flags final sample of symbol)
module tx_sym_timer
  import gdsp_pkg::*;
#(
  parameter int N = SPS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt;
  assign last = cnt == W'(N - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: TX frame sequencer (start/abort/cont_mode/payload_len in; busy, sym_tick, sym_src, sym_bits, frame_start, done, aborted, frame_cnt, state_dbg out)
module tx_frame_ctrl
  import gdsp_pkg::*;
#(
  parameter int PREAMBLE_LEN = 16,
  parameter int GUARD_LEN = 8,
  parameter int LEN_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cont_mode,
  input  logic [LEN_W-1:0]        payload_len,
  output logic                    busy,
  output logic                    sym_tick,
  output logic [1:0]              sym_src,
  output logic [BITS_PER_SYM-1:0] sym_bits,
  output logic                    frame_start,
  output logic                    done,
  output logic                    aborted,
  output logic [15:0]             frame_cnt,
  output logic [1:0]              state_dbg
);
  tx_frm_state_t state, state_n;
  logic [LEN_W-1:0] sym_cnt, sym_cnt_n, len_q, len_n, phase_last;
  logic last, active, kill, adv, fin, fin_frame, accept, restart;
  assign active = state != IDLE;
  assign kill = abort & active;
  assign adv = en & last & active & ~abort;
  assign phase_last = state == PREAMBLE ? LEN_W'(PREAMBLE_LEN - 1) :
                      state == PAYLOAD  ? len_q - 1'b1 : LEN_W'(GUARD_LEN - 1);
  assign fin = adv & (sym_cnt == phase_last);
  assign fin_frame = fin & (state == GUARD);
  assign accept = ~active & start & en & ~abort;
  assign restart = fin_frame & (cont_mode | start);
  tx_sym_timer #(.N(SPS)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (~active | kill),
    .en  (en),
    .last(last)
  );
  always_comb begin
    state_n = kill ? IDLE : accept ? PREAMBLE : !fin ? state :
              state == PREAMBLE ? (len_q == '0 ? GUARD : PAYLOAD) :
              state == PAYLOAD ? GUARD : restart ? PREAMBLE : IDLE;
    sym_cnt_n = (kill | accept | fin) ? '0 : adv ? sym_cnt + 1'b1 : sym_cnt;
    len_n = (accept | restart) ? payload_len : len_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      len_q       <= '0;
      busy        <= 1'b0;
      sym_tick    <= 1'b0;
      sym_src     <= '0;
      sym_bits    <= '0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      frame_cnt   <= '0;
      state_dbg   <= '0;
    end else begin
      state       <= state_n;
      sym_cnt     <= sym_cnt_n;
      len_q       <= len_n;
      busy        <= state_n != IDLE;
      sym_tick    <= accept | (adv & (state_n != IDLE));
      sym_src     <= state_n == PAYLOAD ? SRC_PRBS : state_n == GUARD ? SRC_ZERO : SRC_PRE;
      sym_bits    <= state_n == PREAMBLE ? (sym_cnt_n[0] ? PRE_SYM_B : PRE_SYM_A) : '0;
      frame_start <= accept | restart;
      done        <= fin_frame;
      aborted     <= kill;
      frame_cnt   <= fin_frame ? frame_cnt + 16'd1 : frame_cnt;
      state_dbg   <= state_n;
    end
  end
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: directed table-driven bench for tx_frame_ctrl
module tb_tx_frame_ctrl;
  logic clk = 0, rst = 1, en = 1, start = 0, abort = 0, cont_mode = 0;
  logic [11:0] payload_len = '0;
  logic busy, sym_tick, frame_start, done, aborted;
  logic [1:0] sym_src, state_dbg;
  logic [3:0] sym_bits;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_fc = 0;
  typedef struct {
    logic [11:0] len;
    int start_at;
    int gap_at;
    int exp_ticks;
    int exp_done;
  } vec_t;
  vec_t vecs[5];
  tx_frame_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
    .cont_mode(cont_mode), .payload_len(payload_len), .busy(busy),
    .sym_tick(sym_tick), .sym_src(sym_src), .sym_bits(sym_bits),
    .frame_start(frame_start), .done(done), .aborted(aborted),
    .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input vec_t v);
    int c, ticks, last_t;
    logic seen_done;
    logic [1:0] exp_src;
    payload_len = v.len;
    start = 1;
    c = 0;
    ticks = 0;
    last_t = 0;
    seen_done = 0;
    while (!seen_done && c < 400) begin
      step();
      c++;
      if (sym_tick) begin
        exp_src = ticks < 16 ? 2'd0 : ticks < 16 + int'(v.len) ? 2'd1 : 2'd2;
        chk("sym_src", sym_src, exp_src);
        chk("sym_bits", sym_bits, ticks < 16 ? ((ticks % 2) ? 4'hF : 4'h0) : 4'h0);
        chk("frame_start", frame_start, ticks == 0);
        chk("tick_interval", c - last_t,
            ticks == 0 ? 1 : (v.gap_at != 0 && last_t < v.gap_at && c > v.gap_at) ? 9 : 4);
        ticks++;
        last_t = c;
      end
      if (done) begin
        seen_done = 1;
        exp_fc++;
        chk("done_cycle", c, v.exp_done);
        chk("busy_after_done", busy, 0);
        chk("tick_count", ticks, v.exp_ticks);
        chk("frame_cnt", frame_cnt, exp_fc);
      end else if (!busy) begin
        chk("busy_in_frame", busy, 1);
      end
      start = v.start_at != 0 && c == v.start_at;
      en = !(v.gap_at != 0 && c >= v.gap_at && c < v.gap_at + 5);
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    start = 0;
    en = 1;
    step();
  endtask
  initial begin
    int c;
    vecs[0] = '{12'd10, 0, 0, 34, 137};
    vecs[1] = '{12'd0, 40, 0, 24, 97};
    vecs[2] = '{12'd10, 0, 70, 34, 142};
    vecs[3] = '{12'd1, 0, 0, 25, 101};
    vecs[4] = '{12'd3, 0, 0, 27, 109};
    rst = 1;
    start = 1;
    repeat (3) begin
      step();
      chk("reset_outputs", {busy, sym_tick, sym_src, sym_bits, frame_start, done,
                            aborted, frame_cnt, state_dbg}, 0);
    end
    rst = 0;
    start = 0;
    step();
    chk("idle_after_reset", busy, 0);
    en = 0;
    start = 1;
    repeat (2) begin
      step();
      chk("start_ignored_en0", busy, 0);
    end
    en = 1;
    start = 0;
    step();
    chk("start_not_queued", busy, 0);
    abort = 1;
    start = 1;
    step();
    chk("abort_beats_start", {busy, frame_start}, 0);
    abort = 0;
    start = 0;
    step();
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);
    cont_mode = 1;
    payload_len = 12'd2;
    start = 1;
    c = 0;
    while (c < 300) begin
      step();
      c++;
      start = 0;
      if (c == 105) begin
        exp_fc++;
        chk("b2b_first_end", {done, frame_start, sym_tick, busy}, 4'b1111);
        chk("b2b_first_cnt", frame_cnt, exp_fc);
        cont_mode = 0;
      end else if (c == 209) begin
        exp_fc++;
        chk("b2b_second_end", {done, busy}, 2'b10);
        chk("b2b_second_cnt", frame_cnt, exp_fc);
        break;
      end else if (!busy || done) begin
        chk("b2b_busy_hold", {busy, done}, 2'b10);
      end
    end
    if (c != 209) chk("b2b_timeout", c, 209);
    step();
    payload_len = 12'd10;
    start = 1;
    c = 0;
    while (c < 81) begin
      step();
      c++;
      start = 0;
      if (c == 80) begin
        chk("pre_abort_src", sym_src, 2'd1);
        abort = 1;
      end
    end
    chk("abort_outputs", {busy, aborted, sym_tick, done, state_dbg}, 6'b010000);
    chk("abort_frame_cnt", frame_cnt, exp_fc);
    abort = 0;
    step();
    chk("aborted_pulse", {aborted, busy, done}, 0);
    run_frame(vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
